// File: rtl/vga_pkg.sv
// Shared constants for the VGA pixel path: RGB111 colours and the
// default frame-buffer geometry.
package vga_pkg;

    localparam logic [2:0] BLACK_VGA = 3'b000;
    localparam logic [2:0] RED_VGA   = 3'b100;
    localparam logic [2:0] GREEN_VGA = 3'b010;
    localparam logic [2:0] BLUE_VGA  = 3'b001;

    localparam int SCREEN_X_DEFAULT = 176;
    localparam int SCREEN_Y_DEFAULT = 120;
    localparam int PAGE_SIZE        = SCREEN_X_DEFAULT * SCREEN_Y_DEFAULT;

endpackage

// File: rtl/delay_line.sv
// Fixed-depth shift register; every stage clears asynchronously to CLR so
// the delayed sync/flag bits come out of reset as "inactive".
module delay_line #(
    parameter int           W   = 1,
    parameter int           D   = 1,
    parameter logic [W-1:0] CLR = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);

    logic [W-1:0] stage [D];

    // Shift din through D stages, clearing all stages on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < D; i++) stage[i] <= CLR;
        end else begin
            stage[0] <= din;
            for (int i = 1; i < D; i++) stage[i] <= stage[i-1];
        end
    end

    assign dout = stage[D-1];

endmodule

// File: rtl/vga_fb_scaler.sv
// Pixel fetch and power-of-two scaling between the VGA timing driver and
// the frame buffer. The address is built from incremental counters (no
// multiply/divide); syncs and flags are delayed to line up with read data.
module vga_fb_scaler import vga_pkg::*; #(
    parameter int            SCREEN_X     = SCREEN_X_DEFAULT,
    parameter int            SCREEN_Y     = SCREEN_Y_DEFAULT,
    parameter int            AW           = 16,
    parameter int            DW           = 3,
    parameter int            SCALE_LOG2   = 3,
    parameter int            X_OFF        = 0,
    parameter int            Y_OFF        = 0,
    parameter int            PAGES        = 2,
    parameter int            MEM_LAT      = 1,
    parameter logic [DW-1:0] BORDER_COLOR = DW'(BLACK_VGA)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [10:0]   pos_x,
    input  logic [10:0]   pos_y,
    input  logic          pix_active,
    input  logic          hsync_n_in,
    input  logic          vsync_n_in,
    input  logic          frame_sel,
    output logic [AW-1:0] mem_addr,
    input  logic [DW-1:0] mem_data,
    output logic [DW-1:0] pixel_out,
    output logic          hsync_n_out,
    output logic          vsync_n_out,
    output logic          page_cur
);

    localparam int SXW = (SCALE_LOG2 > 0) ? SCALE_LOG2 : 1;
    localparam int L   = 1 + MEM_LAT;

    localparam logic [11:0]   X_LO     = 12'(X_OFF);
    localparam logic [11:0]   X_HI     = 12'(X_OFF + (SCREEN_X << SCALE_LOG2));
    localparam logic [11:0]   Y_LO     = 12'(Y_OFF);
    localparam logic [11:0]   Y_HI     = 12'(Y_OFF + (SCREEN_Y << SCALE_LOG2));
    localparam logic [SXW-1:0] S_LAST  = SXW'((1 << SCALE_LOG2) - 1);
    localparam logic [AW-1:0] COL_LAST = AW'(SCREEN_X - 1);
    localparam logic [AW-1:0] ROW_STEP = AW'(SCREEN_X);
    localparam logic [AW-1:0] PAGE_OFS = AW'(SCREEN_X * SCREEN_Y);

    logic           x_in_win, y_in_win, at_x_start, line_start, frame_start;
    logic           in_img, page_eff;
    logic           synced_q, synced_cur;
    logic [SXW-1:0] sx_q, sx_cur, sx_nxt, sy_q, sy_cur;
    logic [AW-1:0]  col_q, col_cur, col_nxt, row_q, row_cur, page_base;
    logic [3:0]     dly;

    // Window decode and the strobes that restart column, row and frame.
    always_comb begin
        x_in_win    = ({1'b0, pos_x} >= X_LO) && ({1'b0, pos_x} < X_HI);
        y_in_win    = ({1'b0, pos_y} >= Y_LO) && ({1'b0, pos_y} < Y_HI);
        at_x_start  = (pos_x == 11'(X_OFF));
        line_start  = at_x_start && pix_active;
        frame_start = (pos_x == 11'd0) && (pos_y == 11'd0);
    end

    // Row state for the current line. It changes only at the line start;
    // synced stays low after reset until the first image row is reached so
    // that no pixel is fetched with half-initialised row counters.
    always_comb begin
        sy_cur     = sy_q;
        row_cur    = row_q;
        synced_cur = synced_q;
        if (line_start) begin
            if (pos_y == 11'(Y_OFF)) begin
                sy_cur     = '0;
                row_cur    = '0;
                synced_cur = 1'b1;
            end else if (y_in_win) begin
                if (sy_q == S_LAST) begin
                    sy_cur  = '0;
                    row_cur = row_q + ROW_STEP;
                end else begin
                    sy_cur = sy_q + SXW'(1);
                end
            end
        end
    end

    // Column state for the current pixel and its successor; col saturates
    // at the last image column.
    always_comb begin
        in_img  = pix_active && x_in_win && y_in_win && synced_cur;
        sx_cur  = at_x_start ? '0 : sx_q;
        col_cur = at_x_start ? '0 : col_q;
        sx_nxt  = sx_cur;
        col_nxt = col_cur;
        if (in_img) begin
            if (sx_cur == S_LAST) begin
                sx_nxt  = '0;
                col_nxt = (col_cur == COL_LAST) ? col_cur : col_cur + AW'(1);
            end else begin
                sx_nxt = sx_cur + SXW'(1);
            end
        end
    end

    // A frame_sel change presented on the frame-start cycle already applies
    // to that first pixel.
    always_comb begin
        page_eff  = (PAGES > 1) && (frame_start ? frame_sel : page_cur);
        page_base = page_eff ? PAGE_OFS : '0;
    end

    // Counter, page and address registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sx_q     <= '0;
            col_q    <= '0;
            sy_q     <= '0;
            row_q    <= '0;
            synced_q <= 1'b0;
            page_cur <= 1'b0;
            mem_addr <= '0;
        end else begin
            sx_q     <= sx_nxt;
            col_q    <= col_nxt;
            sy_q     <= sy_cur;
            row_q    <= row_cur;
            synced_q <= synced_cur;
            if ((PAGES > 1) && frame_start) page_cur <= frame_sel;
            if (in_img) mem_addr <= page_base + row_cur + col_cur;
        end
    end

    delay_line #(
        .W   (4),
        .D   (L),
        .CLR (4'b1100)
    ) u_dly (
        .clk   (clk),
        .rst_n (rst),
        .din   ({hsync_n_in, vsync_n_in, pix_active, in_img}),
        .dout  (dly)
    );

    // Output select on the delayed flags: image data, border, or blank.
    always_comb begin
        hsync_n_out = dly[3];
        vsync_n_out = dly[2];
        pixel_out   = '0;
        if (dly[0])      pixel_out = mem_data;
        else if (dly[1]) pixel_out = BORDER_COLOR;
    end

endmodule

// File: tb/tb_vga_fb_scaler.sv
// Bench for vga_fb_scaler. Instance a: default geometry, MEM_LAT=2, two
// pages. Instance b: 4x2 unscaled image at offset (100,50), border 3'b101.
module tb_vga_fb_scaler;

    logic clk;
    logic rst;

    // instance a signals
    logic [10:0] a_x, a_y;
    logic        a_act, a_hs, a_vs, a_fs;
    logic [15:0] a_addr, a_m1, a_m2;
    logic [2:0]  a_data, a_pix;
    logic        a_hso, a_vso, a_page;

    // instance b signals
    logic [10:0] b_x, b_y;
    logic        b_act, b_hs, b_vs, b_fs;
    logic [15:0] b_addr, b_m1;
    logic [2:0]  b_data, b_pix;
    logic        b_hso, b_vso, b_page;

    int n_total = 0;
    int n_bad   = 0;

    // scoreboard state
    logic [4:0]  qa[$];
    logic [26:0] qb[$];
    int   ma_page, ma_synced, a_prev_in, a_prev_addr, a_prev_x, a_prev_y, a_prev_page;
    int   mb_synced, b_prev_in, b_prev_addr, b_prev_x, b_prev_y, b_seq;

    vga_fb_scaler #(.MEM_LAT(2)) dut_a (
        .clk(clk), .rst(rst), .pos_x(a_x), .pos_y(a_y), .pix_active(a_act),
        .hsync_n_in(a_hs), .vsync_n_in(a_vs), .frame_sel(a_fs),
        .mem_addr(a_addr), .mem_data(a_data), .pixel_out(a_pix),
        .hsync_n_out(a_hso), .vsync_n_out(a_vso), .page_cur(a_page)
    );

    vga_fb_scaler #(
        .SCREEN_X(4), .SCREEN_Y(2), .SCALE_LOG2(0), .X_OFF(100), .Y_OFF(50),
        .PAGES(1), .MEM_LAT(1), .BORDER_COLOR(3'b101)
    ) dut_b (
        .clk(clk), .rst(rst), .pos_x(b_x), .pos_y(b_y), .pix_active(b_act),
        .hsync_n_in(b_hs), .vsync_n_in(b_vs), .frame_sel(b_fs),
        .mem_addr(b_addr), .mem_data(b_data), .pixel_out(b_pix),
        .hsync_n_out(b_hso), .vsync_n_out(b_vso), .page_cur(b_page)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // frame-buffer models: data = addr[2:0] after MEM_LAT clocks
    always @(posedge clk) begin
        a_m1 <= a_addr;
        a_m2 <= a_m1;
        b_m1 <= b_addr;
    end
    assign a_data = a_m2[2:0];
    assign b_data = b_m1[2:0];

    task automatic check(input string tag, input int got, input int exp);
        n_total++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic int ref_addr(int x, int y, int xo, int yo, int s, int sx, int page, int psize);
        return page * psize + ((x - xo) >> s) + ((y - yo) >> s) * sx;
    endfunction

    task automatic do_reset();
        @(posedge clk);
        #2;
        rst = 1'b0;
        a_x = 11'd1500; a_act = 1'b0; a_hs = 1'b1; a_vs = 1'b1;
        b_x = 11'd1500; b_act = 1'b0; b_hs = 1'b1; b_vs = 1'b1;
        #1;
        check("a_rst_addr", a_addr, 0);
        check("a_rst_pix", a_pix, 0);
        check("a_rst_hs", a_hso, 1);
        check("a_rst_vs", a_vso, 1);
        check("a_rst_page", a_page, 0);
        check("b_rst_addr", b_addr, 0);
        check("b_rst_pix", b_pix, 0);
        check("b_rst_hs", b_hso, 1);
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b1;
        qa.delete();
        repeat (3) qa.push_back(5'b00011);
        qb.delete();
        repeat (2) qb.push_back({11'h7ff, 11'h7ff, 3'b000, 1'b1, 1'b1});
        ma_page = 0; ma_synced = 0; a_prev_in = 0;
        mb_synced = 0; b_prev_in = 0; b_seq = 0;
    endtask

    task automatic step_a(input int x, input int y, input logic act, input logic hs,
                          input logic vs, input logic fs);
        logic [4:0] e;
        logic [2:0] px;
        int ad, inm;
        @(posedge clk);
        #1;
        if (a_prev_in != 0) begin
            check("a_addr", a_addr, a_prev_addr);
            if (a_prev_page == 0 && a_prev_x == 15 && a_prev_y == 7) check("a_addr_15_7", a_addr, 1);
            if (a_prev_page == 0 && a_prev_x == 0 && a_prev_y == 8) check("a_addr_0_8", a_addr, 176);
            if (a_prev_page == 0 && a_prev_x == 1407 && a_prev_y == 959) check("a_addr_last", a_addr, 21119);
            if (a_prev_page == 1 && a_prev_x == 0 && a_prev_y == 0) check("a_addr_flip", a_addr, 21120);
        end
        if (qa.size() >= 3) begin
            e = qa.pop_front();
            check("a_pix", a_pix, e[4:2]);
            check("a_hsync", a_hso, e[1]);
            check("a_vsync", a_vso, e[0]);
        end
        a_x = 11'(x); a_y = 11'(y); a_act = act; a_hs = hs; a_vs = vs; a_fs = fs;
        if (x == 0 && y == 0) ma_page = fs ? 1 : 0;
        if (act && x == 0 && y == 0) ma_synced = 1;
        inm = (act && x < 1408 && y < 960 && ma_synced != 0) ? 1 : 0;
        ad  = ref_addr(x, y, 0, 0, 3, 176, ma_page, 21120);
        px  = (inm != 0) ? ad[2:0] : 3'b000;
        a_prev_in = inm; a_prev_addr = ad; a_prev_x = x; a_prev_y = y; a_prev_page = ma_page;
        qa.push_back({px, hs, vs});
    endtask

    task automatic step_b(input int x, input int y, input logic act, input logic hs,
                          input logic vs, input logic fs);
        logic [26:0] e;
        logic [2:0]  px;
        int ad, inm;
        @(posedge clk);
        #1;
        if (b_prev_in != 0) begin
            check("b_addr", b_addr, b_prev_addr);
            check("b_addr_seq", b_addr, b_seq);
            b_seq++;
            if (b_prev_x == 100 && b_prev_y == 50) check("b_addr_origin", b_addr, 0);
        end
        if (qb.size() >= 2) begin
            e = qb.pop_front();
            check("b_pix", b_pix, e[4:2]);
            check("b_hsync", b_hso, e[1]);
            check("b_vsync", b_vso, e[0]);
            if (e[26:16] == 11'd99 && e[15:5] == 11'd50) check("b_border_99_50", b_pix, 5);
            if (e[26:16] == 11'd100 && e[15:5] == 11'd49) check("b_border_100_49", b_pix, 5);
        end
        b_x = 11'(x); b_y = 11'(y); b_act = act; b_hs = hs; b_vs = vs; b_fs = fs;
        if (act && x == 100 && y == 50) mb_synced = 1;
        inm = (act && x >= 100 && x < 104 && y >= 50 && y < 52 && mb_synced != 0) ? 1 : 0;
        ad  = ref_addr(x, y, 100, 50, 0, 4, 0, 8);
        px  = (inm != 0) ? ad[2:0] : (act ? 3'b101 : 3'b000);
        b_prev_in = inm; b_prev_addr = ad; b_prev_x = x; b_prev_y = y;
        qb.push_back({11'(x), 11'(y), px, hs, vs});
    endtask

    // one active line of n pixels followed by a short hsync gap
    task automatic a_line(input int y, input int n, input logic fs);
        for (int x = 0; x < n; x++) step_a(x, y, 1'b1, 1'b1, 1'b1, fs);
        step_a(1500, y, 1'b0, 1'b0, 1'b1, fs);
        step_a(1500, y, 1'b0, 1'b0, 1'b1, fs);
        step_a(1500, y, 1'b0, 1'b1, 1'b1, fs);
    endtask

    task automatic a_vgap(input logic fs);
        for (int i = 0; i < 3; i++) step_a(1500, 1000, 1'b0, 1'b1, 1'b0, fs);
        step_a(1500, 1000, 1'b0, 1'b1, 1'b1, fs);
    endtask

    initial begin
        rst = 1'b0;
        a_x = 11'd1500; a_y = 11'd1000; a_act = 1'b0; a_hs = 1'b1; a_vs = 1'b1; a_fs = 1'b0;
        b_x = 11'd1500; b_y = 11'd1000; b_act = 1'b0; b_hs = 1'b1; b_vs = 1'b1; b_fs = 1'b1;
        do_reset();

        // instance b: offset 4x2 window, border around it
        for (int y = 48; y < 54; y++) begin
            for (int x = 96; x < 108; x++) step_b(x, y, 1'b1, 1'b1, 1'b1, 1'b1);
            step_b(1500, y, 1'b0, 1'b0, 1'b1, 1'b1);
            step_b(1500, y, 1'b0, 1'b1, 1'b1, 1'b1);
        end
        step_b(0, 0, 1'b1, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) step_b(1500, 0, 1'b0, 1'b1, 1'b1, 1'b1);
        check("b_page_single", b_page, 0);
        check("b_addr_count", b_seq, 8);

        // instance a, frame 1: short lines, full last line, frame_sel raised mid-frame
        for (int y = 0; y < 960; y++) a_line(y, (y == 959) ? 1408 : 16, (y >= 300) ? 1'b1 : 1'b0);
        a_vgap(1'b1);
        check("a_page_pre", a_page, 0);

        // frame 2: flip to page 1, frame_sel dropped again mid-frame
        for (int y = 0; y < 20; y++) begin
            a_line(y, 16, (y >= 5) ? 1'b0 : 1'b1);
            if (y == 0)  check("a_page_post", a_page, 1);
            if (y == 19) check("a_page_hold", a_page, 1);
        end
        for (int x = 0; x < 6; x++) step_a(x, 20, 1'b1, 1'b1, 1'b1, 1'b0);
        do_reset();
        for (int y = 21; y < 31; y++) a_line(y, 16, 1'b0);
        a_vgap(1'b0);

        // frame 3: frame_sel rises on the frame-start cycle itself
        step_a(0, 0, 1'b1, 1'b1, 1'b1, 1'b1);
        for (int x = 1; x < 16; x++) step_a(x, 0, 1'b1, 1'b1, 1'b1, 1'b1);
        step_a(1500, 0, 1'b0, 1'b0, 1'b1, 1'b1);
        step_a(1500, 0, 1'b0, 1'b1, 1'b1, 1'b1);
        check("a_page_same_cycle", a_page, 1);
        for (int y = 1; y < 16; y++) a_line(y, 16, 1'b1);
        a_vgap(1'b1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
